// File: rtl/uart_pkg.sv
// uart_pkg: register map and bit positions shared by the UART receive buffer.
package uart_pkg;
   localparam logic [1:0] UART_DATA = 2'd0;
   localparam logic [1:0] UART_STAT = 2'd1;
   localparam logic [1:0] UART_CTRL = 2'd2;
   localparam int ST_AVAIL   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_INTEN   = 3;
   localparam int ST_CNT_LSB = 8;
   localparam int CT_INTEN  = 0;
   localparam int CT_CLROVF = 1;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO; a push on full is accepted only alongside a pop.
module uart_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             quick_clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             push_ok, pop_ok;
   assign full    = count == (PTR_W+1)'(DEPTH);
   assign empty   = count == '0;
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];
   always_ff @(posedge quick_clk or negedge reset)
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      end
   // storage is not reset; contents are don't-care until written
   always_ff @(posedge quick_clk)
      if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: buffers received UART bytes in a FIFO behind a DATA/STATUS/CTRL
// register interface with a level interrupt.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        quick_clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_status,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [1:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq
);
   logic             rx_status_q, push, pop, rd, ctrl_wr;
   logic             overflow, int_en, overflow_nx, int_en_nx, empty_nx;
   logic             full, empty;
   logic [7:0]       dout;
   logic [PTR_W:0]   count;
   logic [31:0]      status, rdata_nx;
   assign push    = rx_status & ~rx_status_q;
   assign rd      = bus_sel & ~bus_we;
   assign pop     = rd & (bus_addr == UART_DATA) & ~empty;
   assign ctrl_wr = bus_sel & bus_we & (bus_addr == UART_CTRL);
   // set wins over a simultaneous write-one-to-clear
   assign overflow_nx = (push & full & ~pop) | (overflow & ~(ctrl_wr & bus_wdata[CT_CLROVF]));
   assign int_en_nx   = ctrl_wr ? bus_wdata[CT_INTEN] : int_en;
   // with DEPTH >= 2 a push at count 0 or 1 is never refused, so no full check needed
   assign empty_nx    = ~push & (empty | ((count == (PTR_W+1)'(1)) & pop));
   uart_byte_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .quick_clk(quick_clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .din(rx_data),
      .dout(dout),
      .count(count),
      .full(full),
      .empty(empty)
   );
   always_comb begin
      status = '0;
      status[ST_AVAIL] = ~empty;
      status[ST_FULL] = full;
      status[ST_OVF] = overflow;
      status[ST_INTEN] = int_en;
      status[ST_CNT_LSB +: PTR_W+1] = count;
   end
   assign rdata_nx = bus_addr == UART_DATA ? {24'h0, empty ? 8'h0 : dout} :
                     bus_addr == UART_STAT ? status :
                     bus_addr == UART_CTRL ? {31'h0, int_en} : 32'h0;
   always_ff @(posedge quick_clk or negedge reset)
      if (!reset) begin
         rx_status_q <= 1'b0;
         overflow    <= 1'b0;
         int_en      <= 1'b0;
         bus_rdata   <= '0;
         irq         <= 1'b0;
      end else begin
         rx_status_q <= rx_status;
         overflow    <= overflow_nx;
         int_en      <= int_en_nx;
         if (rd) bus_rdata <= rdata_nx;
         irq         <= int_en_nx & (~empty_nx | overflow_nx);
      end
endmodule
